// File: rtl/sha512_pkg.sv
// Shared types for the SHA-512 read engine: CSR command/descriptor words and
// the subset of CCI-P channel-0 structures the engine touches.
package sha512_pkg;

   typedef logic [1:0] t_hc_control;
   localparam t_hc_control HC_CTL_IDLE  = 2'd0;
   localparam t_hc_control HC_CTL_START = 2'd1;

   typedef struct packed {
      logic [41:0] address;
      logic [31:0] size;
   } t_hc_buffer;

   typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
   typedef enum logic [1:0] {eCL_LEN_1 = 2'd0, eCL_LEN_2 = 2'd1, eCL_LEN_4 = 2'd3} t_ccip_cllen;
   typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_cllen  cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      logic [41:0]  address;
      logic [15:0]  mdata;
   } t_ccip_c0_req_hdr;

   typedef struct packed {
      t_ccip_c0_req_hdr hdr;
      logic             valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_vc    vc_used;
      logic [5:0]  rsvd;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_rsp_hdr;

   typedef struct packed {
      t_ccip_c0_rsp_hdr hdr;
      logic [511:0]     data;
      logic             rspValid;
      logic             mmioRdValid;
      logic             mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_DONE} t_rd_state;

   localparam int RD_ROB_DEPTH = 64;

endpackage

// File: rtl/sha512_rob.sv
// Reorder buffer: register-file line storage with per-slot valid bits and a
// zero-latency head read. Only the valid bits are reset.
module sha512_rob
   import sha512_pkg::*;
#(
   parameter int DEPTH = RD_ROB_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [511:0]     wr_data_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic             rd_clr_i,
   output logic             rd_valid_o,
   output logic [511:0]     rd_data_o
);

   logic [511:0]     mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;

   always_comb begin
      valid_d = valid_q;
      if (rd_clr_i) valid_d[rd_idx_i] = 1'b0;
      if (wr_en_i)  valid_d[wr_idx_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_data_o  = mem_q[rd_idx_i];

   // a second response for a slot still waiting to drain is a host protocol error
   a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
      wr_en_i |-> !valid_q[wr_idx_i]);

endmodule

// File: rtl/sha512_rd_engine.sv
// Streams one host buffer over CCI-P channel 0 and delivers the lines, in
// address order, on a valid/ready stream to the SHA-512 core.
module sha512_rd_engine
   import sha512_pkg::*;
#(
   parameter int ROB_DEPTH = RD_ROB_DEPTH,
   parameter int SIZE_W    = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  t_hc_control    hc_control,
   input  t_hc_buffer     hc_buf,
   input  logic           c0TxAlmFull,
   output t_if_ccip_c0_Tx tx_rd,
   input  t_if_ccip_c0_Rx rx_rd,
   output logic           out_valid,
   output logic [511:0]   out_data,
   output logic           out_last,
   input  logic           out_ready,
   output logic           busy,
   output logic           done
);

   // state    | meaning
   // RD_IDLE  | no transfer since reset
   // RD_RUN   | issuing reads, ROB draining concurrently
   // RD_DRAIN | all reads issued, waiting for the remaining lines to drain
   // RD_DONE  | buffer fully delivered, done held high

   localparam int IDX_W = $clog2(ROB_DEPTH);

   t_rd_state   state_q;
   t_hc_control ctl_q;
   t_hc_control ctl_prev_q;
   logic [41:0] base_q;
   logic [SIZE_W-1:0] total_q;
   logic [SIZE_W-1:0] req_cnt_q;
   logic [SIZE_W-1:0] rel_cnt_q;
   logic [SIZE_W-1:0] rel_cnt_d;
   logic        done_q;
   logic        tx_valid_q;
   logic [41:0] tx_addr_q;
   logic [15:0] tx_mdata_q;

   logic         start;
   logic         credit_ok;
   logic         issue;
   logic         rob_valid;
   logic [511:0] rob_data;
   logic         rel_fire;
   logic         unused_rx;

   assign start     = (ctl_q == HC_CTL_START) && (ctl_prev_q != HC_CTL_START);
   assign busy      = (state_q == RD_RUN) || (state_q == RD_DRAIN);
   assign credit_ok = (req_cnt_q - rel_cnt_q) < SIZE_W'(ROB_DEPTH);
   assign issue     = (state_q == RD_RUN) && (req_cnt_q < total_q) && !c0TxAlmFull && credit_ok;
   assign rel_fire  = rob_valid && out_ready;
   assign rel_cnt_d = rel_cnt_q + {{(SIZE_W-1){1'b0}}, rel_fire};

   sha512_rob #(
      .DEPTH (ROB_DEPTH),
      .IDX_W (IDX_W)
   ) u_rob (
      .clk        (clk),
      .rst_n      (reset),
      .wr_en_i    (rx_rd.rspValid && busy),
      .wr_idx_i   (rx_rd.hdr.mdata[IDX_W-1:0]),
      .wr_data_i  (rx_rd.data),
      .rd_idx_i   (rel_cnt_q[IDX_W-1:0]),
      .rd_clr_i   (rel_fire),
      .rd_valid_o (rob_valid),
      .rd_data_o  (rob_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RD_IDLE;
         ctl_q      <= HC_CTL_IDLE;
         ctl_prev_q <= HC_CTL_IDLE;
         base_q     <= '0;
         total_q    <= '0;
         req_cnt_q  <= '0;
         rel_cnt_q  <= '0;
         done_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_addr_q  <= '0;
         tx_mdata_q <= '0;
      end else begin
         ctl_q      <= hc_control;
         ctl_prev_q <= ctl_q;
         tx_valid_q <= 1'b0;
         rel_cnt_q  <= rel_cnt_d;
         case (state_q)
            RD_IDLE, RD_DONE: begin
               if (start) begin
                  base_q    <= hc_buf.address;
                  total_q   <= SIZE_W'(hc_buf.size);
                  req_cnt_q <= '0;
                  rel_cnt_q <= '0;
                  if (hc_buf.size == '0) begin
                     state_q <= RD_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RD_RUN;
                     done_q  <= 1'b0;
                  end
               end
            end
            RD_RUN: begin
               if (req_cnt_q == total_q) begin
                  state_q <= RD_DRAIN;
               end else if (issue) begin
                  tx_valid_q <= 1'b1;
                  tx_addr_q  <= base_q + 42'(req_cnt_q);
                  tx_mdata_q <= 16'(req_cnt_q[IDX_W-1:0]);
                  req_cnt_q  <= req_cnt_q + SIZE_W'(1);
               end
            end
            RD_DRAIN: begin
               // done lands the cycle right after the final handshake
               if (rel_cnt_d == total_q) begin
                  state_q <= RD_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= RD_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_rd              = '0;
      tx_rd.valid        = tx_valid_q;
      tx_rd.hdr.vc_sel   = eVC_VA;
      tx_rd.hdr.cl_len   = eCL_LEN_1;
      tx_rd.hdr.req_type = eREQ_RDLINE_I;
      tx_rd.hdr.address  = tx_addr_q;
      tx_rd.hdr.mdata    = tx_mdata_q;
   end

   assign out_valid = rob_valid;
   assign out_data  = rob_data;
   assign out_last  = rob_valid && (rel_cnt_q == total_q - SIZE_W'(1));
   assign done      = done_q;

   assign unused_rx = ^{rx_rd.hdr.vc_used, rx_rd.hdr.rsvd, rx_rd.hdr.resp_type,
                        rx_rd.hdr.mdata[15:IDX_W], rx_rd.mmioRdValid, rx_rd.mmioWrValid};

endmodule

// File: tb/tb_sha512_rd_engine.sv
// Scoreboard bench for sha512_rd_engine: expected requests and lines are queued
// at start time and popped by negedge monitors.
`timescale 1ns/1ps
module tb_sha512_rd_engine;
   import sha512_pkg::*;

   localparam int DEPTH = 64;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   t_hc_control    hc_control = HC_CTL_IDLE;
   t_hc_buffer     hc_buf = '0;
   logic           alm = 1'b0;
   t_if_ccip_c0_Tx tx_rd;
   t_if_ccip_c0_Rx rx_rd = '0;
   logic           out_valid;
   logic [511:0]   out_data;
   logic           out_last;
   logic           out_ready = 1'b0;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   sha512_rd_engine #(.ROB_DEPTH(DEPTH), .SIZE_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .hc_control  (hc_control),
      .hc_buf      (hc_buf),
      .c0TxAlmFull (alm),
      .tx_rd       (tx_rd),
      .rx_rd       (rx_rd),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {logic [41:0] addr; logic [15:0] mdata;} req_t;
   typedef struct {logic [511:0] data; logic last;} out_t;

   req_t exp_req_q[$];
   req_t pend_q[$];
   req_t man_q[$];
   out_t exp_out_q[$];
   int   req_cyc_q[$];
   int   hs_cyc_q[$];

   int n_cmp = 0, n_err = 0;
   int cyc = 0, req_n = 0, out_n = 0, ov_n = 0;
   int done_cyc = -1, rsp0_cyc = -1;
   bit auto_rsp = 1'b0, busy_seen = 1'b0;
   logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_done = 1'b0;
   logic [511:0] prev_data = '0;
   int r0, ov0, n0, n1, o0;

   function automatic logic [511:0] mk_line(input logic [41:0] a);
      logic [511:0] l;
      for (int k = 0; k < 8; k++)
         l[k*64 +: 64] = {22'h0, a} ^ {32'hC0DE0000 + 32'(k), 32'h5A5A0000};
      return l;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // host memory model: answers either immediately (auto) or from a scripted order
   always @(posedge clk) begin : responder
      req_t r;
      #1;
      rx_rd.rspValid = 1'b0;
      if (auto_rsp && pend_q.size() > 0) begin
         r = pend_q.pop_front();
         rx_rd.hdr.mdata = r.mdata;
         rx_rd.data      = mk_line(r.addr);
         rx_rd.rspValid  = 1'b1;
      end else if (man_q.size() > 0) begin
         r = man_q.pop_front();
         if (r.mdata == 16'd0) rsp0_cyc = cyc;
         rx_rd.hdr.mdata = r.mdata;
         rx_rd.data      = mk_line(r.addr);
         rx_rd.rspValid  = 1'b1;
      end
   end

   always @(negedge clk) begin : monitor
      req_t e;
      out_t o;
      if (tx_rd.valid) begin
         req_n++;
         req_cyc_q.push_back(cyc);
         if (exp_req_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_req: got addr %0h, want none", tx_rd.hdr.address);
         end else begin
            e = exp_req_q.pop_front();
            chk("req_addr", tx_rd.hdr.address, e.addr);
            chk("req_mdata", tx_rd.hdr.mdata, e.mdata);
            chk("req_hdr", {tx_rd.hdr.vc_sel, tx_rd.hdr.cl_len}, {eVC_VA, eCL_LEN_1});
         end
         pend_q.push_back('{addr: tx_rd.hdr.address, mdata: tx_rd.hdr.mdata});
      end
      if (reset && prev_valid && !prev_ready)
         chk("hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      if (out_valid) ov_n++;
      if (!out_valid) chk("last_without_valid", out_last, 1'b0);
      if (out_valid && out_ready) begin
         hs_cyc_q.push_back(cyc);
         out_n++;
         if (exp_out_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_out: got data %0h, want none", out_data);
         end else begin
            o = exp_out_q.pop_front();
            chk("out_data", out_data, o.data);
            chk("out_last", out_last, o.last);
         end
      end
      if (done && !prev_done) done_cyc = cyc;
      if (busy) busy_seen = 1'b1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_last  = out_last;
      prev_data  = out_data;
      prev_done  = done;
   end

   task automatic start(input logic [41:0] base, input int size);
      for (int i = 0; i < size; i++) begin
         exp_req_q.push_back('{addr: base + 42'(i), mdata: 16'(i % DEPTH)});
         exp_out_q.push_back('{data: mk_line(base + 42'(i)), last: (i == size - 1)});
      end
      req_cyc_q.delete();
      hs_cyc_q.delete();
      done_cyc = -1;
      @(posedge clk); #1;
      hc_buf.address = base;
      hc_buf.size    = 32'(size);
      hc_control     = HC_CTL_START;
      @(posedge clk); #1;
      hc_control = HC_CTL_IDLE;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      repeat (2) @(negedge clk);
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      #1;
      chk(name, done, 1'b1);
      chk({name, "_req_left"}, exp_req_q.size(), 0);
      chk({name, "_out_left"}, exp_out_q.size(), 0);
   endtask

   task automatic wait_reqs(input string name, input int base_n, input int n, input int budget);
      int k;
      k = 0;
      while (req_n - base_n < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      chk(name, req_n - base_n >= n, 1'b1);
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_valid", tx_rd.valid, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(posedge clk); #1 reset = 1'b1;

      // zero-length buffer: done two cycles after start, no traffic
      busy_seen = 1'b0;
      r0 = req_n;
      start(42'h9000, 0);
      @(negedge clk); #1 chk("size0_done_early", done, 1'b0);
      @(negedge clk); #1 chk("size0_done", done, 1'b1);
      repeat (5) @(negedge clk);
      #1;
      chk("size0_busy_never", busy_seen, 1'b0);
      chk("size0_no_req", req_n - r0, 0);

      // in-order, four lines
      auto_rsp = 1'b1;
      @(posedge clk); #1 out_ready = 1'b1;
      o0 = out_n;
      start(42'h1000, 4);
      wait_done("t1_done", 200);
      chk("t1_req_back2back", req_cyc_q[3] - req_cyc_q[0], 3);
      chk("t1_lines", out_n - o0, 4);
      chk("t1_done_after_last", done_cyc, hs_cyc_q[3] + 1);

      // out-of-order responses 3,1,0,2
      auto_rsp = 1'b0;
      o0 = out_n;
      start(42'h4000, 4);
      wait_reqs("t2_reqs", req_n - pend_q.size(), 4, 100);
      if (pend_q.size() == 4) begin
         man_q.push_back(pend_q[3]);
         man_q.push_back(pend_q[1]);
         man_q.push_back(pend_q[0]);
         man_q.push_back(pend_q[2]);
         pend_q.delete();
      end
      wait_done("t2_done", 200);
      chk("t2_lines", out_n - o0, 4);
      chk("t2_first_after_line0", hs_cyc_q[0], rsp0_cyc + 1);
      chk("t2_line1_back2back", hs_cyc_q[1], hs_cyc_q[0] + 1);

      // credit limit: 200 lines, sink stalled
      auto_rsp = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      r0 = req_n;
      o0 = out_n;
      start(42'h8000, 200);
      repeat (150) @(negedge clk);
      #1 chk("t3_credit_stall", req_n - r0, DEPTH);
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done("t3_done", 3000);
      chk("t3_reqs", req_n - r0, 200);
      chk("t3_lines", out_n - o0, 200);

      // almost-full held for ten cycles mid-run
      r0 = req_n;
      start(42'h5000, 20);
      wait_reqs("t4_reqs5", r0, 5, 100);
      alm = 1'b1;
      n0 = req_n;
      repeat (10) @(negedge clk);
      #1 n1 = req_n;
      alm = 1'b0;
      chk("t4_almfull_quiet", n1 - n0, 0);
      wait_done("t4_done", 500);
      chk("t4_reqs", req_n - r0, 20);

      // reset after 5 of 10 requests
      @(posedge clk); #1 out_ready = 1'b0;
      r0 = req_n;
      start(42'h2000, 10);
      wait_reqs("t5_reqs5", r0, 5, 100);
      reset = 1'b0;
      #1;
      chk("t5_rst_tx_valid", tx_rd.valid, 1'b0);
      chk("t5_rst_out_valid", out_valid, 1'b0);
      chk("t5_rst_out_last", out_last, 1'b0);
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_done", done, 1'b0);
      auto_rsp = 1'b0;
      pend_q.delete();
      man_q.delete();
      exp_req_q.delete();
      exp_out_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 5; i++) man_q.push_back('{addr: 42'h2000 + 42'(i), mdata: 16'(i)});
      ov0 = ov_n;
      r0 = req_n;
      repeat (12) @(negedge clk);
      #1;
      chk("t5_late_rsp_dropped", ov_n - ov0, 0);
      chk("t5_no_req_after_rst", req_n - r0, 0);
      auto_rsp = 1'b1;
      @(posedge clk); #1 out_ready = 1'b1;
      o0 = out_n;
      start(42'h3000, 2);
      wait_done("t5_done", 200);
      chk("t5_lines", out_n - o0, 2);
      chk("t5_reqs", req_n - r0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
